// File: rtl/mem_responder.sv
// Word-organised memory responder with valid/ready requests, RV32I sizing and fixed LATENCY.
// Optional MEM_MISALIGN_TRAP_EN: misaligned h/w accesses return resp_err instead of aligning down.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_funct3;

  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [2:0]    sel_f3;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   ext_data;
  logic          calc_err;
  logic [31:0]   calc_rdata;
  logic [3:0]    be;
  logic [31:0]   wword;

  assign req_ready = (state == IDLE);

  // With LATENCY == 1 the response is computed in the accept cycle, so decode from the live request.
  always_comb begin
    sel_we   = (state == IDLE) ? req_we     : lat_we;
    sel_addr = (state == IDLE) ? req_addr   : lat_addr;
    sel_f3   = (state == IDLE) ? req_funct3 : lat_funct3;
    rd_word  = mem[sel_addr[IW+1:2]];
    shifted  = rd_word >> {sel_addr[1:0], 3'b000};
    sel_byte = shifted[7:0];
    sel_half = sel_addr[1] ? rd_word[31:16] : rd_word[15:0];
    calc_err = |sel_addr[31:IW+2];
    if (sel_we)
      calc_err = calc_err | !(sel_f3 == 3'b000 || sel_f3 == 3'b001 || sel_f3 == 3'b010);
    else
      calc_err = calc_err | (sel_f3 == 3'b011 || sel_f3 == 3'b110 || sel_f3 == 3'b111);
`ifdef MEM_MISALIGN_TRAP_EN
    if ((sel_f3[1:0] == 2'b01 && sel_addr[0]) || (sel_f3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00))
      calc_err = 1'b1;
`endif
    case (sel_f3)
      3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ext_data = {24'h0, sel_byte};
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  ext_data = {16'h0, sel_half};
      3'b010:  ext_data = rd_word;
      default: ext_data = '0;
    endcase
    calc_rdata = (calc_err || sel_we) ? '0 : ext_data;
  end

  always_comb begin
    case (lat_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lat_addr[1:0];
        wword = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be    = lat_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{lat_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = lat_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            cnt        <= CW'(LATENCY - 1);
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= calc_rdata;
              resp_err   <= calc_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= calc_rdata;
            resp_err   <= calc_err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stores commit at the edge ending RESP; resp_err already holds the decoded error for this request.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && lat_we && !resp_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[lat_addr[IW+1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RISC-V core: it serves the instruction-fetch and load/store requests that the core's control FSM initiates. It accepts one request at a time over a valid/ready handshake and holds a word-organised backing store. It applies RV32I byte/halfword/word sizing from funct3, including sign/zero extension on loads and byte-lane masking on stores. It returns one response pulse per accepted request after a fixed, parameterised latency, so the core FSM can stall on `req_ready`/`resp_valid` instead of assuming single-cycle memory.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the backing store; a power of two, minimum 4.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid`; integer, minimum 1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; a transfer occurs when `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load/fetch.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the used bytes are taken from the low lanes (sb: [7:0], sh: [15:0]).
- `req_funct3`  in  3  RV32I size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  load result, already extended; 0 for stores and errors.
- `resp_err`  out  1  request rejected; no memory side effect occurred.

## Operation
- States: IDLE, WAIT, RESP. `req_ready` = (state == IDLE).
- IDLE: on a transfer, latch we/addr/wdata/funct3 and load a counter with LATENCY-1.
  - If LATENCY == 1, go to RESP; otherwise go to WAIT.
- WAIT: decrement the counter; move to RESP when the counter is 1.
- RESP: assert `resp_valid`, then return to IDLE unconditionally. There is no response backpressure; the requester must sample `resp_valid` in that cycle.
- Word index = addr[31:2]. Error if the index is >= DEPTH_WORDS.
- Error on store funct3 not in {000,001,010}. Error on load funct3 in {011,110,111}.
- Load extraction:
  - b/bu select byte addr[1:0]; h/hu select halfword addr[1].
  - b and h sign-extend; bu and hu zero-extend; w passes the full word.
- Store commit: byte enables are one lane (sb, lane addr[1:0]), two lanes (sh, lanes selected by addr[1]) or all four (sw). The store commits on the clock edge that ends the RESP cycle. Unaddressed lanes are unchanged.
- Error: no write; `resp_rdata` = 0; `resp_err` = 1.
- `resp_rdata` and `resp_err` are registered. They are valid only with `resp_valid` and hold until the next response.
- Reset: state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, counter = 0. Array contents are not cleared.
- Reset during WAIT or RESP aborts the request: no response is issued and a pending store is not committed.

## Timing
- Request accepted at edge T means `resp_valid` is high during cycle T+LATENCY for exactly one cycle.
- `req_ready` rises in cycle T+LATENCY+1. Maximum throughput is one request per LATENCY+1 cycles.
- A load accepted after a store's RESP cycle observes the stored data; there is no forwarding requirement beyond this.
- `req_*` inputs are ignored while `req_ready` = 0.
- `req_valid` may be held high across the response; this produces back-to-back transfers at maximum throughput.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: the following accesses return `resp_err` = 1 with no write and `resp_rdata` = 0:
  - lh, lhu, sh with addr[0] = 1;
  - lw, sw with addr[1:0] != 0.
- Undefined: misalignment never raises an error. The low address bits below the access size are ignored, so the access is aligned down (h uses addr[1] only; w uses word index only).

## Test plan
- LATENCY=2: sw 0xDEADBEEF to 0x10, then lw 0x10 -> `resp_valid` exactly 2 cycles after each accept, rdata 0xDEADBEEF, err 0; `req_ready` low for 2 cycles after each accept.
- Word 0x20 = 0x80FF7F01: lb 0x22 -> 0xFFFFFFFF; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01.
- Word 0x30 = 0x11223344: sb 0xAA to 0x31, then sh 0xBEEF to 0x32, then lw 0x30 -> 0xBEEFAA44.
- Error cases: lw at byte address DEPTH_WORDS*4 -> err 1, rdata 0. Load with funct3=011 -> err 1. Store with funct3=100 -> err 1 and the word is unchanged.
- `MEM_MISALIGN_TRAP_EN` on: sw 0x12345678 to 0x41 -> err 1 and words 0x40/0x44 unchanged. Macro off: same store -> err 0 and word 0x40 = 0x12345678.
- Store accepted, then `reset` asserted for one cycle during WAIT -> no `resp_valid`, target word unchanged, `req_ready` = 1 in the cycle after reset.
